// File: rtl/rv32_pkg.sv
// Shared RV32I back-end types: writeback select, bubble encoding and the
// EX/MEM and MEM/WB stage register layouts.
package rv32_pkg;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } WBSel_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2data;
        logic        regwen;
        logic        memrw;
        WBSel_t      wbsel;
        logic        valid;
    } exmem_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] ldata;
        logic        regwen;
        WBSel_t      wbsel;
        logic        valid;
    } memwb_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with reset > hold > bubble > load priority.
// The bubble value is supplied by the instantiating stage.
module pipe_stage_reg #(
    parameter type T      = logic [31:0],
    parameter T    BUBBLE = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic bubble,
    input  T     d,
    output T     q
);

    always_ff @(posedge clk) begin
        if (rst)         q <= BUBBLE;
        else if (hold)   q <= q;
        else if (bubble) q <= BUBBLE;
        else             q <= d;
    end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers, writeback mux and retired-instruction
// counter for the 5-stage RV32I core.
module ex_mem_wb_pipe
    import rv32_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_ENC,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_MEM,
    input  logic             flush_EX,
    input  logic             valid_EX,
    input  logic [31:0]      inst_EX,
    input  logic [31:0]      pc_EX,
    input  logic [31:0]      alu_EX,
    input  logic [31:0]      rs2data_EX,
    input  logic             RegWEn_EX,
    input  logic             MemRW_EX,
    input  WBSel_t           WBSel_EX,
    output logic [31:0]      inst_MEM,
    output logic [31:0]      pc_MEM,
    output logic [31:0]      alu_MEM,
    output logic [31:0]      rs2data_MEM,
    output logic             RegWEn_MEM,
    output logic             MemRW_MEM,
    output logic             valid_MEM,
    output WBSel_t           WBSel_MEM,
    input  logic [31:0]      dmem_rdata_MEM,
    output logic [31:0]      inst_WB,
    output logic             RegWEn_WB,
    output logic             valid_WB,
    output logic [31:0]      wb_data_WB,
    output logic [CNT_W-1:0] instret
);

    localparam exmem_t EXMEM_BUBBLE = '{
        inst: NOP_INST, pc: 32'd0, alu: 32'd0, rs2data: 32'd0,
        regwen: 1'b0, memrw: 1'b0, wbsel: WB_ALU, valid: 1'b0
    };

    localparam memwb_t MEMWB_BUBBLE = '{
        inst: NOP_INST, pc4: 32'd0, alu: 32'd0, ldata: 32'd0,
        regwen: 1'b0, wbsel: WB_ALU, valid: 1'b0
    };

    exmem_t exmem_d;
    exmem_t exmem_q;
    memwb_t memwb_d;
    memwb_t memwb_q;

    always_comb begin
        exmem_d = '{
            inst: inst_EX, pc: pc_EX, alu: alu_EX, rs2data: rs2data_EX,
            regwen: RegWEn_EX, memrw: MemRW_EX, wbsel: WBSel_EX, valid: 1'b1
        };
    end

    // A stalled MEM keeps its instruction; a pending flush is re-asserted later.
    pipe_stage_reg #(
        .T      (exmem_t),
        .BUBBLE (EXMEM_BUBBLE)
    ) u_exmem (
        .clk    (clk),
        .rst    (rst),
        .hold   (stall_MEM),
        .bubble (flush_EX | ~valid_EX),
        .d      (exmem_d),
        .q      (exmem_q)
    );

    always_comb begin
        memwb_d = '{
            inst: exmem_q.inst, pc4: exmem_q.pc + 32'd4, alu: exmem_q.alu,
            ldata: dmem_rdata_MEM, regwen: exmem_q.regwen,
            wbsel: exmem_q.wbsel, valid: exmem_q.valid
        };
    end

    // Bubbling WB during a stall stops the held MEM instruction retiring twice.
    pipe_stage_reg #(
        .T      (memwb_t),
        .BUBBLE (MEMWB_BUBBLE)
    ) u_memwb (
        .clk    (clk),
        .rst    (rst),
        .hold   (1'b0),
        .bubble (stall_MEM),
        .d      (memwb_d),
        .q      (memwb_q)
    );

    assign inst_MEM    = exmem_q.inst;
    assign pc_MEM      = exmem_q.pc;
    assign alu_MEM     = exmem_q.alu;
    assign rs2data_MEM = exmem_q.rs2data;
    assign RegWEn_MEM  = exmem_q.regwen;
    assign MemRW_MEM   = exmem_q.memrw;
    assign valid_MEM   = exmem_q.valid;
    assign WBSel_MEM   = exmem_q.wbsel;

    assign inst_WB     = memwb_q.inst;
    assign RegWEn_WB   = memwb_q.regwen;
    assign valid_WB    = memwb_q.valid;

    always_comb begin
        case (memwb_q.wbsel)
            WB_ALU:  wb_data_WB = memwb_q.alu;
            WB_MEM:  wb_data_WB = memwb_q.ldata;
            WB_PC4:  wb_data_WB = memwb_q.pc4;
            default: wb_data_WB = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)           instret <= '0;
        else if (valid_WB) instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Bench for ex_mem_wb_pipe: table vectors, hand-written multi-cycle sequences
// and random traffic, checked against a stage model and a writeback scoreboard.
module tb_ex_mem_wb_pipe;
    import rv32_pkg::*;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] MEM_KEY = 32'h5A5A_5A5A;

    localparam exmem_t MEM_BUBBLE = '{
        inst: NOP, pc: 32'd0, alu: 32'd0, rs2data: 32'd0,
        regwen: 1'b0, memrw: 1'b0, wbsel: WB_ALU, valid: 1'b0
    };

    logic        clk = 1'b0;
    logic        rst, stall_MEM, flush_EX, valid_EX;
    logic [31:0] inst_EX, pc_EX, alu_EX, rs2data_EX;
    logic        RegWEn_EX, MemRW_EX;
    WBSel_t      WBSel_EX;
    logic [31:0] dmem_rdata_MEM;

    logic [31:0] inst_MEM, pc_MEM, alu_MEM, rs2data_MEM;
    logic        RegWEn_MEM, MemRW_MEM, valid_MEM;
    WBSel_t      WBSel_MEM;
    logic [31:0] inst_WB, wb_data_WB;
    logic        RegWEn_WB, valid_WB;
    logic [63:0] instret;

    logic [31:0] inst_MEM_s, pc_MEM_s, alu_MEM_s, rs2data_MEM_s;
    logic        RegWEn_MEM_s, MemRW_MEM_s, valid_MEM_s;
    WBSel_t      WBSel_MEM_s;
    logic [31:0] inst_WB_s, wb_data_WB_s;
    logic        RegWEn_WB_s, valid_WB_s;
    logic [3:0]  instret_s;

    always #5 clk = ~clk;

    ex_mem_wb_pipe dut (
        .clk(clk), .rst(rst), .stall_MEM(stall_MEM), .flush_EX(flush_EX),
        .valid_EX(valid_EX), .inst_EX(inst_EX), .pc_EX(pc_EX), .alu_EX(alu_EX),
        .rs2data_EX(rs2data_EX), .RegWEn_EX(RegWEn_EX), .MemRW_EX(MemRW_EX),
        .WBSel_EX(WBSel_EX), .inst_MEM(inst_MEM), .pc_MEM(pc_MEM),
        .alu_MEM(alu_MEM), .rs2data_MEM(rs2data_MEM), .RegWEn_MEM(RegWEn_MEM),
        .MemRW_MEM(MemRW_MEM), .valid_MEM(valid_MEM), .WBSel_MEM(WBSel_MEM),
        .dmem_rdata_MEM(dmem_rdata_MEM), .inst_WB(inst_WB), .RegWEn_WB(RegWEn_WB),
        .valid_WB(valid_WB), .wb_data_WB(wb_data_WB), .instret(instret)
    );

    // Narrow counter build shares stimulus so the wrap can be reached quickly.
    ex_mem_wb_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_MEM(stall_MEM), .flush_EX(flush_EX),
        .valid_EX(valid_EX), .inst_EX(inst_EX), .pc_EX(pc_EX), .alu_EX(alu_EX),
        .rs2data_EX(rs2data_EX), .RegWEn_EX(RegWEn_EX), .MemRW_EX(MemRW_EX),
        .WBSel_EX(WBSel_EX), .inst_MEM(inst_MEM_s), .pc_MEM(pc_MEM_s),
        .alu_MEM(alu_MEM_s), .rs2data_MEM(rs2data_MEM_s), .RegWEn_MEM(RegWEn_MEM_s),
        .MemRW_MEM(MemRW_MEM_s), .valid_MEM(valid_MEM_s), .WBSel_MEM(WBSel_MEM_s),
        .dmem_rdata_MEM(dmem_rdata_MEM), .inst_WB(inst_WB_s), .RegWEn_WB(RegWEn_WB_s),
        .valid_WB(valid_WB_s), .wb_data_WB(wb_data_WB_s), .instret(instret_s)
    );

    int          n_vec = 0;
    int          n_err = 0;
    exmem_t      exp_mem = MEM_BUBBLE;
    logic        exp_wb_valid = 1'b0;
    logic [63:0] exp_instret = '0;
    logic [64:0] exp_q[$];

    typedef struct {
        logic        valid;
        logic        flush;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic        regwen;
        logic        memrw;
        WBSel_t      wbsel;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wb_ref(input WBSel_t sel, input logic [31:0] pc,
                                           input logic [31:0] alu);
        case (sel)
            WB_ALU:  return alu;
            WB_MEM:  return alu ^ MEM_KEY;
            WB_PC4:  return pc + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_ex(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic regwen, input logic memrw, input WBSel_t sel);
        valid_EX   = v;
        inst_EX    = inst;
        pc_EX      = pc;
        alu_EX     = alu;
        rs2data_EX = rs2;
        RegWEn_EX  = regwen;
        MemRW_EX   = memrw;
        WBSel_EX   = sel;
    endtask

    task automatic idle();
        set_ex(1'b0, NOP, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, WB_ALU);
    endtask

    // One clock: predict both stages, advance, then compare.
    task automatic tick(input logic [31:0] exp_wb);
        logic        retire;
        logic        mv;
        logic [64:0] popped;
        exmem_t      act_mem;
        retire = exp_wb_valid;
        mv     = !rst && !stall_MEM && exp_mem.valid;
        popped = '0;
        if (mv) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry");
            end else begin
                popped = exp_q.pop_front();
            end
        end
        if (rst) begin
            exp_mem = MEM_BUBBLE;
            exp_q.delete();
            exp_instret = '0;
        end else begin
            if (!stall_MEM) begin
                if (flush_EX || !valid_EX) begin
                    exp_mem = MEM_BUBBLE;
                end else begin
                    exp_mem = '{inst: inst_EX, pc: pc_EX, alu: alu_EX, rs2data: rs2data_EX,
                                regwen: RegWEn_EX, memrw: MemRW_EX, wbsel: WBSel_EX,
                                valid: 1'b1};
                    exp_q.push_back({RegWEn_EX, inst_EX, exp_wb});
                end
            end
            if (retire) exp_instret = exp_instret + 64'd1;
        end
        exp_wb_valid = mv;

        @(posedge clk);
        #1;
        act_mem = '{inst: inst_MEM, pc: pc_MEM, alu: alu_MEM, rs2data: rs2data_MEM,
                    regwen: RegWEn_MEM, memrw: MemRW_MEM, wbsel: WBSel_MEM,
                    valid: valid_MEM};
        check("mem_regs", 160'(act_mem), 160'(exp_mem));
        check("valid_WB", 160'(valid_WB), 160'(exp_wb_valid));
        if (exp_wb_valid)
            check("wb_out", 160'({RegWEn_WB, inst_WB, wb_data_WB}), 160'(popped));
        else
            check("wb_bubble", 160'({RegWEn_WB, inst_WB}), 160'({1'b0, NOP}));
        check("instret", 160'(instret), 160'(exp_instret));
        check("instret_4b", 160'(instret_s), 160'(exp_instret[3:0]));
        dmem_rdata_MEM = exp_mem.alu ^ MEM_KEY;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h00A0_0293, 32'h0000_0010, 32'd10, 32'd0,
                    1'b1, 1'b0, WB_ALU, 32'd10};
        vecs[1] = '{1'b1, 1'b0, 32'h0002_A303, 32'h0000_0014, 32'h0000_1000, 32'd0,
                    1'b1, 1'b0, WB_MEM, 32'h5A5A_4A5A};
        vecs[2] = '{1'b1, 1'b0, 32'h0080_006F, 32'h0000_0100, 32'h0000_0108, 32'd0,
                    1'b1, 1'b0, WB_PC4, 32'h0000_0104};
        vecs[3] = '{1'b1, 1'b0, 32'h0080_00EF, 32'hFFFF_FFFC, 32'h0000_0004, 32'd0,
                    1'b1, 1'b0, WB_PC4, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b0, 32'h0062_A023, 32'h0000_0020, 32'h0000_2000, 32'hCAFE_F00D,
                    1'b0, 1'b1, WB_ALU, 32'h0000_2000};
        vecs[5] = '{1'b1, 1'b0, 32'h0050_0313, 32'h0000_0024, 32'h0000_0055, 32'd0,
                    1'b1, 1'b0, WBSel_t'(2'd3), 32'h0000_0000};
        vecs[6] = '{1'b0, 1'b0, 32'h0010_0093, 32'h0000_0028, 32'h0000_0077, 32'd0,
                    1'b1, 1'b0, WB_ALU, 32'd0};
        vecs[7] = '{1'b1, 1'b1, 32'h0020_0113, 32'h0000_002C, 32'h0000_0099, 32'd0,
                    1'b1, 1'b0, WB_ALU, 32'd0};

        // Reset overrides a valid instruction and a stall.
        rst = 1'b1; stall_MEM = 1'b1; flush_EX = 1'b0;
        dmem_rdata_MEM = MEM_KEY;
        set_ex(1'b1, 32'h00A0_0293, 32'd0, 32'd10, 32'd0, 1'b1, 1'b0, WB_ALU);
        tick(32'd10);
        check("reset_inst", 160'({inst_MEM, inst_WB}), 160'({32'h0000_0013, 32'h0000_0013}));
        rst = 1'b0; stall_MEM = 1'b0;

        // addi x5: MEM after 1 edge, WB after 2, counted after 3.
        set_ex(1'b1, 32'h00A0_0293, 32'd0, 32'd10, 32'd0, 1'b1, 1'b0, WB_ALU);
        tick(32'd10);
        idle();
        tick(32'd0);
        check("addi_wb", 160'({valid_WB, wb_data_WB}), 160'({1'b1, 32'd10}));
        tick(32'd0);
        check("addi_instret", 160'(instret), 160'(64'd1));

        // Load held in MEM by a two-cycle stall.
        set_ex(1'b1, 32'h0002_A303, 32'h0000_0040, 32'h84F7_E4B5, 32'd0, 1'b1, 1'b0, WB_MEM);
        tick(32'hDEAD_BEEF);
        set_ex(1'b1, 32'h0013_0393, 32'h0000_0044, 32'h0000_0007, 32'd0, 1'b1, 1'b0, WB_ALU);
        stall_MEM = 1'b1;
        tick(32'd7);
        tick(32'd7);
        check("load_held", 160'({inst_MEM, valid_WB}), 160'({32'h0002_A303, 1'b0}));
        stall_MEM = 1'b0;
        tick(32'd7);
        check("load_wb", 160'(wb_data_WB), 160'(32'hDEAD_BEEF));
        idle();
        tick(32'd0);
        tick(32'd0);
        check("load_instret", 160'(instret), 160'(64'd3));

        // jal followed by a flushed slot.
        set_ex(1'b1, 32'h0080_006F, 32'h0000_0100, 32'h0000_0108, 32'd0, 1'b1, 1'b0, WB_PC4);
        tick(32'h0000_0104);
        set_ex(1'b1, 32'h0010_0093, 32'h0000_0104, 32'h0000_0001, 32'd0, 1'b1, 1'b0, WB_ALU);
        flush_EX = 1'b1;
        tick(32'd1);
        flush_EX = 1'b0;
        check("flush_slot", 160'({valid_MEM, RegWEn_MEM}), 160'(2'b00));
        check("jal_wb", 160'(wb_data_WB), 160'(32'h0000_0104));

        // Stall and flush together: EX/MEM keeps its contents, WB bubbles.
        set_ex(1'b1, 32'h0030_0193, 32'h0000_0200, 32'h0000_0003, 32'd0, 1'b1, 1'b0, WB_ALU);
        tick(32'd3);
        set_ex(1'b1, 32'h0040_0213, 32'h0000_0204, 32'h0000_0004, 32'd0, 1'b1, 1'b0, WB_ALU);
        stall_MEM = 1'b1; flush_EX = 1'b1;
        tick(32'd4);
        check("stall_flush", 160'({inst_MEM, valid_MEM, valid_WB}),
              160'({32'h0030_0193, 1'b1, 1'b0}));
        stall_MEM = 1'b0; flush_EX = 1'b0;
        idle();
        tick(32'd0);
        tick(32'd0);

        for (int i = 0; i < 8; i++) begin
            flush_EX = vecs[i].flush;
            set_ex(vecs[i].valid, vecs[i].inst, vecs[i].pc, vecs[i].alu, vecs[i].rs2,
                   vecs[i].regwen, vecs[i].memrw, vecs[i].wbsel);
            tick(vecs[i].exp_wb);
        end
        flush_EX = 1'b0;
        idle();
        tick(32'd0);
        tick(32'd0);

        // Random traffic including stalls, flushes and mid-stream resets.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] r_pc;
            logic [31:0] r_alu;
            WBSel_t      r_sel;
            r_pc  = $urandom();
            r_alu = $urandom();
            r_sel = WBSel_t'(2'($urandom_range(0, 3)));
            rst       = ($urandom_range(0, 39) == 0);
            stall_MEM = ($urandom_range(0, 3) == 0);
            flush_EX  = ($urandom_range(0, 5) == 0);
            set_ex(($urandom_range(0, 3) != 0), $urandom(), r_pc, r_alu, $urandom(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_sel);
            tick(wb_ref(r_sel, r_pc, r_alu));
        end
        rst = 1'b0; stall_MEM = 1'b0; flush_EX = 1'b0;

        // Sixteen retirements wrap the 4-bit counter back to zero.
        rst = 1'b1;
        idle();
        tick(32'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_ex(1'b1, 32'h0000_0093 + (i << 20), 32'h0000_1000 + 4 * i, i, 32'd0,
                   1'b1, 1'b0, WB_ALU);
            tick(32'(i));
        end
        idle();
        for (int i = 0; i < 3; i++) tick(32'd0);
        check("instret_wrap", 160'({instret_s, instret}), 160'({4'd0, 64'd16}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
